// File: rtl/single_cycle_alu_datapath_pkg.sv
// rtl/single_cycle_alu_datapath_pkg.sv - shared widths, instruction fields and ALU opcodes
package single_cycle_alu_datapath_pkg;

    localparam int XLEN    = 64;
    localparam int PC_W    = 14;
    localparam int RA_W    = 6;
    localparam int IMEM_AW = PC_W - 2;
    localparam int NREGS   = 1 << RA_W;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 6;
    localparam int RS1_LSB = 12;
    localparam int RS2_LSB = 18;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rd;
        alu_op_e         op;
    } instr_fields_t;

    // Reserved bits [5:3] and [63:24] are deliberately dropped here.
    function automatic instr_fields_t decode_instr(input logic [XLEN-1:0] word);
        instr_fields_t f;
        f.op  = alu_op_e'(word[OP_LSB +: 3]);
        f.rd  = word[RD_LSB  +: RA_W];
        f.rs1 = word[RS1_LSB +: RA_W];
        f.rs2 = word[RS2_LSB +: RA_W];
        return f;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 64-bit ALU with zero/carry/overflow flags
module alu
    import single_cycle_alu_datapath_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            carry,
    output logic            ovf
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // Two's-complement subtract: bit XLEN is the no-borrow flag.
        diff   = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[XLEN-1:0];
                carry  = sum[XLEN];
                ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff[XLEN-1:0];
                carry  = diff[XLEN];
                ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[5:0];
            ALU_SRL: result = a >> b[5:0];
            ALU_SLT: result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/ram.sv
// rtl/ram.sv - instruction memory, combinational read and synchronous write
module ram
    import single_cycle_alu_datapath_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [XLEN-1:0]    rdata
);

    logic [XLEN-1:0] mem [1 << IMEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 64 x 64 registers, three read ports, one write port, reset-clear
module register_file
    import single_cycle_alu_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RA_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [RA_W-1:0] raddr3,
    output logic [XLEN-1:0] rdata3
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
    assign rdata3 = regs[raddr3];

endmodule

// File: rtl/single_cycle_alu_datapath.sv
// rtl/single_cycle_alu_datapath.sv - single-cycle fetch, register read, ALU and writeback
module single_cycle_alu_datapath
    import single_cycle_alu_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [XLEN-1:0] imem_wdata,
    input  logic [RA_W-1:0] dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [PC_W-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_carry,
    output logic            alu_ovf
);

    instr_fields_t   fields;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [1:0]      unused_byte_offset;

    assign unused_byte_offset = imem_waddr[1:0];
    assign fields             = decode_instr(instr);

    ram u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr[PC_W-1:2]),
        .wdata (imem_wdata),
        .raddr (pc[PC_W-1:2]),
        .rdata (instr)
    );

    // Reset priority over writeback is resolved inside the register file.
    register_file u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (run),
        .waddr  (fields.rd),
        .wdata  (alu_result),
        .raddr1 (fields.rs1),
        .rdata1 (rs1_data),
        .raddr2 (fields.rs2),
        .rdata2 (rs2_data),
        .raddr3 (dbg_raddr),
        .rdata3 (dbg_rdata)
    );

    alu u_alu (
        .op     (fields.op),
        .a      (rs1_data),
        .b      (rs2_data),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (run) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_single_cycle_alu_datapath.sv
// tb/tb_single_cycle_alu_datapath.sv - scoreboard bench with a behavioural datapath model
module tb_single_cycle_alu_datapath;
    import single_cycle_alu_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run, imem_we;
    logic [13:0] imem_waddr;
    logic [63:0] imem_wdata;
    logic [5:0]  dbg_raddr;
    logic [63:0] dbg_rdata, instr, alu_result;
    logic [13:0] pc;
    logic        alu_zero, alu_carry, alu_ovf;

    single_cycle_alu_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc),
        .instr      (instr),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] pc;
        logic [63:0] instr;
        logic [63:0] res;
        logic        z, c, v;
        logic [5:0]  da;
        logic [63:0] dexp;
    } exp_t;

    exp_t        q[$];
    logic [63:0] rf_m[64];
    logic [63:0] im_m[4096];
    int          pc_m;
    int          n_chk = 0;
    int          n_fail = 0;

    bit          ovr = 0;
    logic [63:0] ovr_res;
    logic        ovr_z, ovr_c, ovr_v;

    function automatic logic [63:0] enc(input int op, input int rd, input int rs1, input int rs2);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[2:0]   = 3'(op);
        w[11:6]  = 6'(rd);
        w[17:12] = 6'(rs1);
        w[23:18] = 6'(rs2);
        return w;
    endfunction

    function automatic void ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic z, output logic c, output logic v);
        longint sa, sb, sr;
        sa = a;
        sb = b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: begin
                r  = a + b;
                sr = r;
                c  = (r < a);
                v  = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
            end
            3'd1: begin
                r  = a - b;
                sr = r;
                c  = (a >= b);
                v  = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << (b % 64);
            3'd6: r = a >> (b % 64);
            default: r = (sa < sb) ? 64'd1 : 64'd0;
        endcase
        z = (r == 64'd0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input bit r, input logic [5:0] da, input bit we, input logic [11:0] wword,
                        input logic [63:0] wd);
        exp_t        e;
        logic [63:0] ins, a, b, res;
        logic        z, c, v;
        @(posedge clk);
        #1;
        run        = r;
        dbg_raddr  = da;
        imem_we    = we;
        imem_waddr = {wword, 2'($urandom)};
        imem_wdata = wd;
        ins = im_m[pc_m / 4];
        a   = rf_m[ins[17:12]];
        b   = rf_m[ins[23:18]];
        ref_alu(ins[2:0], a, b, res, z, c, v);
        e.pc    = 14'(pc_m);
        e.instr = ins;
        e.res   = ovr ? ovr_res : res;
        e.z     = ovr ? ovr_z : z;
        e.c     = ovr ? ovr_c : c;
        e.v     = ovr ? ovr_v : v;
        e.da    = da;
        e.dexp  = rf_m[da];
        q.push_back(e);
        ovr = 0;
        if (we) im_m[wword] = wd;
        if (r) begin
            rf_m[ins[11:6]] = res;
            pc_m = (pc_m + 4) % 16384;
        end
    endtask

    task automatic directed(input logic [63:0] res, input logic z, input logic c, input logic v);
        ovr     = 1;
        ovr_res = res;
        ovr_z   = z;
        ovr_c   = c;
        ovr_v   = v;
        step(1, 6'($urandom), 0, 0, 0);
    endtask

    task automatic load(input logic [11:0] w, input logic [63:0] d);
        @(posedge clk);
        #1;
        run        = 0;
        imem_we    = 1;
        imem_waddr = {w, 2'($urandom)};
        imem_wdata = d;
        im_m[w]    = d;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        run     = 0;
        imem_we = 0;
    endtask

    task automatic poke(input int i, input logic [63:0] v);
        dut.u_rf.regs[i] <= v;
        rf_m[i] = v;
    endtask

    task automatic do_reset(input bit run_during);
        @(posedge clk);
        #1;
        rst     = 1;
        run     = run_during;
        imem_we = 0;
        @(posedge clk);
        #1;
        rst  = 0;
        run  = 0;
        pc_m = 0;
        for (int i = 0; i < 64; i++) rf_m[i] = 64'd0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", 64'(pc), 64'(e.pc));
                chk("instr", instr, e.instr);
                chk("alu_result", alu_result, e.res);
                chk("alu_zero", 64'(alu_zero), 64'(e.z));
                chk("alu_carry", 64'(alu_carry), 64'(e.c));
                chk("alu_ovf", 64'(alu_ovf), 64'(e.v));
                chk($sformatf("dbg_rdata[%0d]", e.da), dbg_rdata, e.dexp);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit seen_top, wrapped;
        int iter;
        rst = 0; run = 0; imem_we = 0; imem_waddr = '0; imem_wdata = '0; dbg_raddr = '0;

        load(0, enc(0, 3, 1, 2));
        load(1, enc(1, 12, 5, 6));
        load(2, enc(1, 13, 7, 8));
        load(3, enc(5, 14, 9, 10));
        load(4, enc(6, 15, 14, 10));
        load(5, enc(7, 16, 11, 9));
        load(6, enc(4, 17, 5, 6));
        load(7, enc(0, 4, 4, 4));
        for (int w = 8; w < 4096; w++)
            load(12'(w), enc($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));

        idle_cycle();
        poke(5, 64'hDEAD_BEEF_0000_0001);
        poke(33, 64'h1234_5678_9ABC_DEF0);
        poke(63, 64'hFFFF_FFFF_FFFF_FFFF);
        do_reset(1);
        for (int i = 0; i < 64; i++) step(0, 6'(i), 0, 0, 0);

        idle_cycle();
        poke(1, 64'h7FFF_FFFF_FFFF_FFFF);
        poke(2, 64'd1);
        poke(4, 64'd2);
        poke(5, 64'd5);
        poke(6, 64'd5);
        poke(7, 64'd0);
        poke(8, 64'd1);
        poke(9, 64'd1);
        poke(10, 64'd63);
        poke(11, 64'hFFFF_FFFF_FFFF_FFFF);
        directed(64'h8000_0000_0000_0000, 0, 0, 1);
        directed(64'd0, 1, 1, 0);
        directed(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        directed(64'h8000_0000_0000_0000, 0, 0, 0);
        directed(64'd1, 0, 0, 0);
        directed(64'd1, 0, 0, 0);
        directed(64'd0, 1, 0, 0);
        directed(64'd4, 0, 0, 0);

        step(0, 4, 1, 8, enc(2, 20, 1, 11));
        step(0, 3, 0, 0, 0);
        step(0, 13, 0, 0, 0);

        idle_cycle();
        for (int i = 0; i < 64; i++) poke(i, {$urandom, $urandom});
        seen_top = 0;
        wrapped  = 0;
        iter     = 0;
        while (!wrapped && iter < 6000) begin
            if (pc_m == 16380) seen_top = 1;
            step($urandom_range(0, 9) != 0, 6'($urandom), $urandom_range(0, 49) == 0,
                 12'($urandom_range(8, 4095)), enc($urandom_range(0, 7), $urandom_range(0, 63),
                 $urandom_range(0, 63), $urandom_range(0, 63)));
            if (seen_top && pc_m == 0) wrapped = 1;
            iter++;
        end
        n_chk++;
        if (!wrapped) begin
            n_fail++;
            $display("FAIL pc_wrap: got no wrap after %0d cycles expected wrap to 0", iter);
        end

        for (int i = 0; i < 5; i++) step(1, 6'($urandom), 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) step(0, 6'($urandom), 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 6'($urandom), 0, 0, 0);
        step(0, 6'($urandom), 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/single_cycle_alu_datapath.md
# single_cycle_alu_datapath

Single-cycle register-to-register execution datapath built from three leaf blocks: instruction memory (`ram`), 64×64 register file (`register_file`) and 64-bit `alu`. Each clock it fetches the 64-bit instruction at `pc`, reads two source registers, computes the ALU result and writes it to the destination register, then advances `pc` by 4. It is the execution core that later control and branch logic will build on.

## Interface
- `PC_W`, 14: program counter / instruction memory byte-address width.
- `XLEN`, 64: data and instruction width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = execute one instruction per cycle; 0 = hold `pc`, no register write.
- `imem_we`  in  1  instruction memory write enable (program load).
- `imem_waddr`  in  14  byte address of load word; bits [1:0] ignored.
- `imem_wdata`  in  64  instruction word to load.
- `dbg_raddr`  in  6  debug register read address.
- `dbg_rdata`  out  64  contents of register `dbg_raddr` (combinational).
- `pc`  out  14  current program counter.
- `instr`  out  64  instruction at `pc` (combinational).
- `alu_result`  out  64  ALU result of current instruction.
- `alu_zero`, `alu_carry`, `alu_ovf`  out  1 each  ALU flags of current instruction.

## Operation
- Instruction fields: [2:0] op, [5:3] reserved (ignored), [11:6] rd, [17:12] rs1, [23:18] rs2, [63:24] reserved (ignored).
- Instruction memory: 4096 × 64-bit words, word index = address[13:2]. Read combinational; write synchronous when `imem_we`=1. Not cleared by reset; `imem_we` works regardless of `rst`/`run`.
- Register file: 64 × 64-bit, two combinational read ports (rs1, rs2) plus debug port, one synchronous write port. Register 0 is an ordinary register (not hardwired to zero). All registers cleared to 0 by `rst`.
- ALU, a = R[rs1], b = R[rs2]:
  - 000 add, a+b; carry = carry-out bit 64; ovf = signed overflow.
  - 001 sub, a−b; carry = no-borrow (a ≥ b unsigned); ovf = signed overflow.
  - 010 and; 011 or; 100 xor.
  - 101 sll, a << b[5:0]; 110 srl (logical), a >> b[5:0]; 111 slt, 1 if signed a < b else 0.
  - carry and ovf are 0 for ops 010–111; zero = (result == 0) for all ops.
- Each cycle with `run`=1 and `rst`=0: R[rd] ← alu_result; pc ← pc + 4.

## Timing
- `rst`=1 at a rising edge: pc ← 0, all registers ← 0; no register write that cycle. `rst` has priority over `run`.
- Fetch, register read and ALU are combinational; writeback and pc update occur on the same edge. Latency is one cycle per instruction, with no stalls or hazards.
- rd equal to rs1/rs2: the read returns the old value; the new value is visible after the edge.
- `dbg_rdata` reflects a write only after the edge that performs it.
- A same-cycle imem write to the address at `pc` fetches the old word; the new word appears after the edge.
- pc wraps modulo 2^14: 16380 + 4 → 0.
- `run`=0: pc, registers frozen; outputs still track the current `pc` combinationally.
- Asserting `rst` mid-program returns to pc=0 with cleared registers; imem contents are kept.

## Structure
- Shared package: `XLEN`, `PC_W`, register-address width 6, instruction field bit positions, and ALU opcode constants (ADD, SUB, AND, OR, XOR, SLL, SRL, SLT).
- Sub-modules:
  - `alu`: pure combinational.
  - `ram`: instruction memory.
  - `register_file`: reset-clearable.
- Top level holds only the pc register and wiring.

## Test plan
- Reset: pulse `rst`, then sample → pc=0; `dbg_rdata`=0 for all 64 addresses.
- Add with overflow:
  - R1 = 0x7FFF_FFFF_FFFF_FFFF, R2 = 1 via preload program; then execute add rd=3, rs1=1, rs2=2.
  - Response: R3 = 0x8000_0000_0000_0000, ovf=1, carry=0, zero=0.
- Sub to zero:
  - Execute sub with a=b=5.
  - Response: result=0, zero=1, carry=1.
  - Execute sub with 0−1.
  - Response: 0xFFFF_FFFF_FFFF_FFFF, carry=0.
- Shift/slt/logic:
  - sll 1 by 63 → 0x8000_0000_0000_0000.
  - srl of that by 63 → 1.
  - slt −1 < 1 → 1.
  - xor equal operands → 0.
- Hold and wrap:
  - `run`=0 for 3 cycles → pc and registers unchanged.
  - Set pc to 16380, then one cycle → pc=0.
- rd = rs1 hazard: R4=2; add rd=4, rs1=4, rs2=4 → R4=4 after the edge; `alu_result` before the edge = 4.
